button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001: The block SHALL have parameter DB_CYCLES, default 1_000_000, giving the debounce stable-time in clk cycles (20 ms at 50 MHz); legal range is 2 or more.
REQ-002: The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003: The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004: The block SHALL have port start_btn, input, 1 bit: raw asynchronous start button, active-low (0 = pressed).
REQ-005: The block SHALL have port stop_btn, input, 1 bit: raw asynchronous stop button, active-low.
REQ-006: The block SHALL have port record_btn, input, 1 bit: raw asynchronous record-view button, active-low.
REQ-007: The block SHALL have port start, output, 1 bit: debounced start level, active-low; drives the timer's start.
REQ-008: The block SHALL have port stop, output, 1 bit: debounced stop level, active-low; drives the timer's stop.
REQ-009: The block SHALL have port see_the_record, output, 1 bit: debounced record level, active-high (1 = held).
REQ-010: The block SHALL have port start_pulse, output, 1 bit: one-cycle high pulse per accepted start press.
REQ-011: The block SHALL have port stop_pulse, output, 1 bit: one-cycle high pulse per accepted stop press.
REQ-012: The block SHALL have port glitch_cnt, output, 8 bits, present only when GLITCH_CNT_EN is defined: saturating count of rejected bounces.

Function
REQ-013: Each raw input SHALL pass through a 2-flop synchronizer before use; no raw input reaches any other logic.
REQ-014: Each channel SHALL run an independent FSM with states REL, PRESS_WAIT, PRESSED and REL_WAIT, plus its own counter of width clog2(DB_CYCLES).
- REL: synchronized input 0 -> PRESS_WAIT, counter cleared to 0.
- PRESS_WAIT: input 1 -> REL (glitch); input 0 and counter = DB_CYCLES-1 -> PRESSED; otherwise counter increments.
- PRESSED: input 1 -> REL_WAIT, counter cleared to 0.
- REL_WAIT: input 0 -> PRESSED (glitch); input 1 and counter = DB_CYCLES-1 -> REL; otherwise counter increments.
REQ-015: The debounced level SHALL be registered and show "pressed" exactly while the state is PRESSED or REL_WAIT.
REQ-016: Latency SHALL be fixed: if raw input is first sampled low at edge e and stays low, the level shows pressed from edge e+2+DB_CYCLES; release is symmetric.
REQ-017: start_pulse and stop_pulse SHALL go high for exactly one cycle on the edge their channel enters PRESSED from PRESS_WAIT; a REL_WAIT->PRESSED re-entry SHALL NOT pulse.
REQ-018: The record channel SHALL produce a level only and no pulse.
REQ-019: Channels SHALL be fully independent; simultaneous presses SHALL yield both pulses in the same cycle.
REQ-020: A button held indefinitely SHALL yield exactly one pulse; the counter SHALL NOT wrap or advance in REL or PRESSED.

Reset
REQ-021: With reset = 0 at a rising edge, the block SHALL set: synchronizer flops to 1, FSMs to REL, counters to 0, start = 1, stop = 1, see_the_record = 0, pulses = 0 and glitch_cnt = 0.
REQ-022: Reset asserted mid-debounce or mid-press SHALL abandon the operation; a button still held after release of reset SHALL need a full new debounce and SHALL produce a new pulse.

Configuration
REQ-023: With macro GLITCH_CNT_EN defined, the block SHALL provide glitch_cnt, incrementing by the number of channels taking a glitch transition (PRESS_WAIT->REL or REL_WAIT->PRESSED) in that cycle and saturating at 255.
REQ-024: With GLITCH_CNT_EN undefined, the glitch_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (DB_CYCLES = 4)
REQ-025: The bench SHALL check clean press: start_btn low from edge 0 -> start = 0 from edge 6, and start_pulse high during cycle 6 only.
REQ-026: The bench SHALL check bounce rejection: stop_btn low 2 cycles, high 1, then low steady -> exactly one stop_pulse, at 6 edges after the last falling sample; glitch_cnt = 1 (macro on).
REQ-027: The bench SHALL check simultaneous presses: start_btn and stop_btn low at the same edge -> both pulses in the same cycle, both levels low.
REQ-028: The bench SHALL check release: record_btn low 20 cycles then high -> see_the_record rises at +6 and falls 6 edges after the release is sampled; no pulses.
REQ-029: The bench SHALL check reset mid-press: reset = 0 for 1 cycle while start is held in PRESSED -> start = 1 next cycle, then a second start_pulse 6 edges after reset release.
REQ-030: The bench SHALL check saturation: more than 300 forced glitches (macro on) -> glitch_cnt holds at 255.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchronizer plus debounce FSM for the start, stop and record buttons.
// Define GLITCH_CNT_EN to add the saturating rejected-bounce counter on glitch_cnt.
module button_conditioner #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       record_btn,
  output logic       start,
  output logic       stop,
  output logic       see_the_record,
  output logic       start_pulse,
  output logic       stop_pulse
`ifdef GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int unsigned N_CH  = 3;
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_REL        = 2'd0,
    S_PRESS_WAIT = 2'd1,
    S_PRESSED    = 2'd2,
    S_REL_WAIT   = 2'd3
  } state_e;

  // Channel order: 0 = start, 1 = stop, 2 = record
  logic [N_CH-1:0] w_raw;
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] w_level;
  logic [1:0]      w_pulse;
`ifdef GLITCH_CNT_EN
  logic [N_CH-1:0] w_glitch;
`endif

  assign w_raw = {record_btn, stop_btn, start_btn};

  // Synchronizers idle at the released (high) level
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             w_in;
    logic             w_cnt_last;

    assign w_in       = r_sync2[i];
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state <= S_REL;
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        S_REL: begin
          if (!w_in) w_state_nxt = S_PRESS_WAIT;
        end
        S_PRESS_WAIT: begin
          if (w_in)            w_state_nxt = S_REL;
          else if (w_cnt_last) w_state_nxt = S_PRESSED;
        end
        S_PRESSED: begin
          if (w_in) w_state_nxt = S_REL_WAIT;
        end
        S_REL_WAIT: begin
          if (!w_in)           w_state_nxt = S_PRESSED;
          else if (w_cnt_last) w_state_nxt = S_REL;
        end
        default: w_state_nxt = S_REL;
      endcase
    end

    // Level is taken from the next state so it changes on the same edge as the FSM
    always_comb begin
      w_cnt_nxt   = r_cnt;
      w_level_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_REL_WAIT);
      case (r_state)
        S_REL: begin
          if (!w_in) w_cnt_nxt = '0;
        end
        S_PRESS_WAIT: begin
          if (!w_in && !w_cnt_last) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        S_PRESSED: begin
          if (w_in) w_cnt_nxt = '0;
        end
        S_REL_WAIT: begin
          if (w_in && !w_cnt_last) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        default: w_cnt_nxt = '0;
      endcase
    end

    assign w_level[i] = r_level;

    if (i < 2) begin : g_pulse
      logic r_pulse;

      // Only a fresh press pulses; a REL_WAIT re-entry does not
      always_ff @(posedge clk) begin
        if (!reset) r_pulse <= 1'b0;
        else        r_pulse <= (r_state == S_PRESS_WAIT) && (w_state_nxt == S_PRESSED);
      end

      assign w_pulse[i] = r_pulse;
    end

`ifdef GLITCH_CNT_EN
    assign w_glitch[i] = ((r_state == S_PRESS_WAIT) &&  w_in) ||
                         ((r_state == S_REL_WAIT)   && !w_in);
`endif
  end

`ifdef GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;
  logic [9:0] w_glitch_sum;

  assign w_glitch_sum = 10'(r_glitch_cnt) + 10'(w_glitch[0]) +
                        10'(w_glitch[1]) + 10'(w_glitch[2]);

  always_ff @(posedge clk) begin
    if (!reset) r_glitch_cnt <= '0;
    else        r_glitch_cnt <= (w_glitch_sum > 10'd255) ? 8'hFF : w_glitch_sum[7:0];
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

  assign start          = ~w_level[0];
  assign stop           = ~w_level[1];
  assign see_the_record =  w_level[2];
  assign start_pulse    =  w_pulse[0];
  assign stop_pulse     =  w_pulse[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized + directed bench for button_conditioner (DB_CYCLES = 4) against a run-length model.
module tb_button_conditioner;

  localparam int DB = 4;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       rec;
    logic       sp;
    logic       tp;
    logic [7:0] gc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_btn = 1'b1;
  logic stop_btn = 1'b1;
  logic record_btn = 1'b1;
  logic start, stop, see_the_record, start_pulse, stop_pulse;
`ifdef GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   cnt_sp = 0;
  int   cnt_tp = 0;
  int   cnt_both = 0;

  // Model: released/pressed level per channel, run of opposite samples, 2-deep input delay
  logic [2:0] m_lvl, m_d1, m_d2, m_pulse;
  int         m_run [3];
  int         m_gc;

  always #5 clk = ~clk;

  button_conditioner #(.DB_CYCLES(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_btn     (start_btn),
    .stop_btn      (stop_btn),
    .record_btn    (record_btn),
    .start         (start),
    .stop          (stop),
    .see_the_record(see_the_record),
    .start_pulse   (start_pulse),
    .stop_pulse    (stop_pulse)
`ifdef GLITCH_CNT_EN
    ,
    .glitch_cnt    (glitch_cnt)
`endif
  );

  // A level flips after DB+1 consecutive opposite samples; a shorter run that is broken is a glitch
  function automatic void model_edge(input logic rst, input logic [2:0] raw);
    int g;
    logic pr;
    g = 0;
    for (int c = 0; c < 3; c++) begin
      m_pulse[c] = 1'b0;
      if (!rst) begin
        m_lvl[c] = 1'b0;
        m_run[c] = 0;
        m_d1[c]  = 1'b1;
        m_d2[c]  = 1'b1;
      end else begin
        pr = ~m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = raw[c];
        if (pr != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB + 1) begin
            m_lvl[c]   = pr;
            m_run[c]   = 0;
            m_pulse[c] = pr;
          end
        end else begin
          if (m_run[c] > 0) g = g + 1;
          m_run[c] = 0;
        end
      end
    end
    if (!rst) m_gc = 0;
    else      m_gc = (m_gc + g > 255) ? 255 : m_gc + g;
  endfunction

  // raw bits: {record, stop, start}, 0 = pressed
  task automatic step(input logic rst, input logic [2:0] raw);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    start_btn  = raw[0];
    stop_btn   = raw[1];
    record_btn = raw[2];
    model_edge(rst, raw);
    e.start = ~m_lvl[0];
    e.stop  = ~m_lvl[1];
    e.rec   =  m_lvl[2];
    e.sp    =  m_pulse[0];
    e.tp    =  m_pulse[1];
    e.gc    =  8'(m_gc);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic steps(input int n, input logic rst, input logic [2:0] raw);
    for (int k = 0; k < n; k++) step(rst, raw);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  exp_t mon_e;
  logic mon_bad;

  // Monitor: one expected vector per clock edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_bad = 1'b0;
      n_vec++;
      if (start !== mon_e.start) begin
        mon_bad = 1'b1;
        $display("FAIL start cyc=%0d got %b expected %b", cyc, start, mon_e.start);
      end
      if (stop !== mon_e.stop) begin
        mon_bad = 1'b1;
        $display("FAIL stop cyc=%0d got %b expected %b", cyc, stop, mon_e.stop);
      end
      if (see_the_record !== mon_e.rec) begin
        mon_bad = 1'b1;
        $display("FAIL see_the_record cyc=%0d got %b expected %b", cyc, see_the_record, mon_e.rec);
      end
      if (start_pulse !== mon_e.sp) begin
        mon_bad = 1'b1;
        $display("FAIL start_pulse cyc=%0d got %b expected %b", cyc, start_pulse, mon_e.sp);
      end
      if (stop_pulse !== mon_e.tp) begin
        mon_bad = 1'b1;
        $display("FAIL stop_pulse cyc=%0d got %b expected %b", cyc, stop_pulse, mon_e.tp);
      end
`ifdef GLITCH_CNT_EN
      if (glitch_cnt !== mon_e.gc) begin
        mon_bad = 1'b1;
        $display("FAIL glitch_cnt cyc=%0d got %0d expected %0d", cyc, glitch_cnt, mon_e.gc);
      end
`endif
      if (mon_bad) n_bad++;
    end
    if (start_pulse === 1'b1) cnt_sp++;
    if (stop_pulse === 1'b1) cnt_tp++;
    if (start_pulse === 1'b1 && stop_pulse === 1'b1) cnt_both++;
  end

  initial begin
    int         s_sp, s_tp, s_both;
    logic [2:0] cur;
    int         hold [3];
    int         guard;

    m_lvl = '0; m_d1 = '1; m_d2 = '1; m_pulse = '0;
    m_gc  = 0;
    for (int c = 0; c < 3; c++) m_run[c] = 0;

    steps(2, 1'b0, 3'b111);

    // Clean start press
    s_sp = cnt_sp; s_tp = cnt_tp;
    steps(12, 1'b1, 3'b110);
    @(negedge clk);
    check_int("clean_press_start_pulses", cnt_sp - s_sp, 1);
    check_int("clean_press_stop_pulses", cnt_tp - s_tp, 0);
    steps(10, 1'b1, 3'b111);

    // Bouncy stop press
    s_tp = cnt_tp;
    steps(2, 1'b1, 3'b101);
    steps(1, 1'b1, 3'b111);
    steps(12, 1'b1, 3'b101);
    @(negedge clk);
    check_int("bounce_stop_pulses", cnt_tp - s_tp, 1);
    steps(10, 1'b1, 3'b111);

    // Simultaneous start + stop
    s_both = cnt_both; s_sp = cnt_sp; s_tp = cnt_tp;
    steps(12, 1'b1, 3'b100);
    @(negedge clk);
    check_int("simul_both_same_cycle", cnt_both - s_both, 1);
    check_int("simul_start_pulses", cnt_sp - s_sp, 1);
    check_int("simul_stop_pulses", cnt_tp - s_tp, 1);
    steps(10, 1'b1, 3'b111);

    // Record hold and release: level only
    s_sp = cnt_sp; s_tp = cnt_tp;
    steps(20, 1'b1, 3'b011);
    steps(12, 1'b1, 3'b111);
    @(negedge clk);
    check_int("record_start_pulses", cnt_sp - s_sp, 0);
    check_int("record_stop_pulses", cnt_tp - s_tp, 0);

    // Reset while start is held in PRESSED
    s_sp = cnt_sp;
    steps(12, 1'b1, 3'b110);
    steps(1, 1'b0, 3'b110);
    steps(12, 1'b1, 3'b110);
    @(negedge clk);
    check_int("reset_mid_press_pulses", cnt_sp - s_sp, 2);
    steps(10, 1'b1, 3'b111);

    // Forced glitches on all channels for saturation
    steps(1, 1'b0, 3'b111);
    for (int k = 0; k < 110; k++) begin
      step(1'b1, 3'b000);
      step(1'b1, 3'b111);
    end
    steps(4, 1'b1, 3'b111);
`ifdef GLITCH_CNT_EN
    @(negedge clk);
    check_int("glitch_saturation", int'(glitch_cnt), 255);
`endif

    // Random stimulus with occasional reset
    cur = 3'b111;
    for (int c = 0; c < 3; c++) hold[c] = $urandom_range(0, 8);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          cur[c]  = ~cur[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 14));
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      step(($urandom_range(0, 255) == 0) ? 1'b0 : 1'b1, cur);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors never checked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
